ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device transmitter for the PS/2 keyboard port. It sends one command byte (LED set 0xED, reset 0xFF, echo 0xEE) to the keyboard using the PS/2 host-request protocol and reports whether the device acknowledged it. It shares the open-drain PS2Clk/PS2Data lines with the `ps2` receiver; top level ties each line to `1'b0` when its `*_drive_low` output is 1 and to `1'bz` otherwise. It runs on the 100 MHz system `clk`.

## Interface
- `INHIBIT_CYCLES`, default 10000: number of `clk` cycles the host holds PS2Clk low before the request (100 µs).
- `TIMEOUT_CYCLES`, default 1500000: maximum number of `clk` cycles from clock release to the ACK edge (15 ms).
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high.
- `tx_data` input 8: byte to send, LSB first.
- `tx_valid` input 1: a byte is offered.
- `tx_ready` output 1: block accepts a byte this cycle.
- `ps2_clk_in` input 1: raw PS2Clk line state (asynchronous).
- `ps2_data_in` input 1: raw PS2Data line state (asynchronous).
- `ps2_clk_drive_low` output 1: 1 pulls PS2Clk low.
- `ps2_data_drive_low` output 1: 1 pulls PS2Data low.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle pulse when a transfer ends (success or failure).
- `ack_ok` output 1: valid while `done`=1; 1 means the device sent ACK (data low at edge 11).

## Operation
- Input conditioning:
  - 2-flop synchronizer on each of `ps2_clk_in` and `ps2_data_in`.
  - Falling edge (`fe`) = synchronized clock was 1 and is now 0.
- Handshake:
  - A byte is accepted when `tx_valid & tx_ready`.
  - `tx_data` is latched into a shift register in that cycle.
  - Odd parity bit is latched as `~^tx_data`.
  - `tx_ready` = 1 only in IDLE.
- States:
  - IDLE: both drive outputs 0. On accept, go to INHIBIT and reset the counter.
  - INHIBIT: `ps2_clk_drive_low`=1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
  - REQ: `ps2_clk_drive_low`=1 and `ps2_data_drive_low`=1 for 1 cycle (start bit, data held low). Then go to XFER with clock released, edge count = 0, timeout counter = 0.
  - XFER: `ps2_clk_drive_low`=0. `ps2_data_drive_low` holds start (low) until fe #1. On each `fe`, increment the edge count n:
    - n=1..8: `ps2_data_drive_low` = ~data bit n-1.
    - n=9: `ps2_data_drive_low` = ~parity.
    - n=10: `ps2_data_drive_low` = 0 (stop; line released).
    - n=11: sample synced data; ACK = (data==0). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synced lines = 1, then emit `done` with `ack_ok`=ACK and go to IDLE.
  - Timeout: if the timeout counter reaches `TIMEOUT_CYCLES` in XFER or WAIT_IDLE:
    - release both lines the same cycle;
    - emit `done` with `ack_ok`=0;
    - go to IDLE.
- Counters:
  - One shared counter of ceil(log2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)) bits.
  - Edge count is 4 bits and never exceeds 11.
- The receiver sees the device's ACK byte (0xFA) independently; this block does not parse it.
- `tx_valid` asserted while `busy` is ignored; no queueing.

## Timing
- Reset values while `reset`=1:
  - IDLE state; `ps2_clk_drive_low`=0, `ps2_data_drive_low`=0.
  - `busy`=0, `done`=0, `ack_ok`=0.
  - `tx_ready`=0, going to 1 on the first cycle after `reset` falls.
- Reset mid-transfer: both drive outputs go to 0 on the next clock edge. No `done` pulse.
- Accept at cycle T:
  - `busy`=1 and `ps2_clk_drive_low`=1 from T+1.
  - Clock stays low for `INHIBIT_CYCLES`+1 cycles.
  - `ps2_data_drive_low` rises at T+1+`INHIBIT_CYCLES`.
- Data edge latency: drive output updates 3 cycles after the raw falling edge (2 sync + 1 register). This is well inside the device's ~40 µs half-period.
- `done` is high for exactly 1 cycle; `busy` falls in that same cycle; `tx_ready`=1 the next cycle.
- Edge 11 and timeout in the same cycle: the edge wins.
- Glitch-free requirement: drive outputs are registered only, never combinational.

## Test plan
- Send 0xED with a device BFM (sample on rising edge, ~12.5 kHz clock, ACK low on pulse 11) -> BFM receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `done`=1, `ack_ok`=1.
- Send 0x00 and 0x01 back-to-back (`tx_valid` held high) -> parity 1 then 0. Second accept happens only after `done` + 1 cycle. `tx_valid` is ignored while `busy`.
- `INHIBIT_CYCLES`=50: measure from accept -> PS2Clk low for 51 cycles; PS2Data low for the last 1 cycle before clock release.
- BFM never clocks, `TIMEOUT_CYCLES`=1000 -> `done`=1 with `ack_ok`=0 exactly 1000 cycles after clock release; both lines released.
- BFM leaves data high at pulse 11 (NACK) -> `done`=1, `ack_ok`=0, 0xFF sent with parity 1.
- Assert `reset` at edge 5 of a transfer -> both drive outputs 0 next cycle; no `done`; `tx_ready`=1 after reset releases; next send 0xEE completes with `ack_ok`=1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device using the host-request
// protocol and reports whether the device acknowledged it.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGE_W  = 4;

  localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [EDGE_W-1:0] EDGE_PARITY  = EDGE_W'(8);
  localparam logic [EDGE_W-1:0] EDGE_STOP    = EDGE_W'(9);
  localparam logic [EDGE_W-1:0] EDGE_ACK     = EDGE_W'(10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_XFER,
    S_WAIT_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                ack_q, ack_d;
  logic                clk_drive_q, clk_drive_d;
  logic                data_drive_q, data_drive_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ack_ok_q, ack_ok_d;
  logic                tx_ready_q, tx_ready_d;

  logic                clk_s1_q, clk_s2_q, clk_prev_q;
  logic                data_s1_q, data_s2_q;

  logic                accept;
  logic                fe;
  logic                timeout;
  logic [CNT_W-1:0]    cnt_inc;

  assign accept  = tx_valid & tx_ready_q;
  assign fe      = clk_prev_q & ~clk_s2_q;
  assign timeout = (cnt_q >= TIMEOUT_LAST);
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Two-flop synchronizers on the raw lines plus the delayed clock for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      edge_cnt_q   <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      ack_q        <= 1'b0;
      clk_drive_q  <= 1'b0;
      data_drive_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_ok_q     <= 1'b0;
      tx_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      ack_q        <= ack_d;
      clk_drive_q  <= clk_drive_d;
      data_drive_q <= data_drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ack_ok_q     <= ack_ok_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  // Next-state logic; drive values are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    edge_cnt_d   = edge_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    ack_d        = ack_q;
    clk_drive_d  = 1'b0;
    data_drive_d = 1'b0;
    done_d       = 1'b0;
    ack_ok_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d     = tx_data;
          parity_d    = ~^tx_data;
          cnt_d       = '0;
          clk_drive_d = 1'b1;
          state_d     = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        clk_drive_d = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_q == INHIBIT_LAST) begin
          data_drive_d = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        // Release the clock, keep the start bit on data.
        data_drive_d = 1'b1;
        cnt_d        = '0;
        edge_cnt_d   = '0;
        state_d      = S_XFER;
      end

      S_XFER: begin
        cnt_d        = cnt_inc;
        data_drive_d = data_drive_q;
        if (fe) begin
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          if (edge_cnt_q < EDGE_PARITY) begin
            data_drive_d = ~shift_q[0];
            shift_d      = {1'b0, shift_q[7:1]};
          end else if (edge_cnt_q == EDGE_PARITY) begin
            data_drive_d = ~parity_q;
          end else if (edge_cnt_q == EDGE_STOP) begin
            data_drive_d = 1'b0;
          end else if (edge_cnt_q == EDGE_ACK) begin
            data_drive_d = 1'b0;
            ack_d        = ~data_s2_q;
            state_d      = S_WAIT_IDLE;
          end
        end else if (timeout) begin
          data_drive_d = 1'b0;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (clk_s2_q && data_s2_q) begin
          done_d   = 1'b1;
          ack_ok_d = ack_q;
          state_d  = S_IDLE;
        end else if (timeout) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs; ready returns only after a full cycle back in idle.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  assign tx_ready           = tx_ready_q;
  assign ps2_clk_drive_low  = clk_drive_q;
  assign ps2_data_drive_low = data_drive_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign ack_ok             = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INHIBIT = 50;
  localparam int unsigned TIMEOUT = 1000;
  localparam int          H       = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       busy;
  logic       done;
  logic       ack_ok;

  logic       bfm_clk_low = 1'b0;
  logic       bfm_data_low = 1'b0;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  int vectors = 0;
  int miscompares = 0;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_line  = ~(ps2_clk_drive_low | bfm_clk_low);
  assign ps2_data_line = ~(ps2_data_drive_low | bfm_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .ps2_clk_in        (ps2_clk_line),
    .ps2_data_in       (ps2_data_line),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .busy              (busy),
    .done              (done),
    .ack_ok            (ack_ok)
  );

  always #5 clk = ~clk;

  // Raise tx_valid with a byte and return at the negedge where it will be accepted.
  task automatic accept_byte(input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Device model: wait for the request, clock out pulses, sample data on rising edges.
  task automatic bfm_xfer(input bit ack, input int pulses, output logic [10:0] frame, output bit ok);
    ok    = 1'b0;
    frame = '1;
    for (int i = 0; i < 300; i++) begin
      if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    frame[0] = ps2_data_line;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= pulses; i++) begin
      if (i == 11 && ack) begin
        bfm_data_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      bfm_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bfm_clk_low = 1'b0;
      if (i <= 10) frame[i] = ps2_data_line;
      if (i == 11) bfm_data_low = 1'b0;
      if (i < pulses) repeat (H) @(negedge clk);
    end
  endtask

  // Advance until done is seen (bounded); return at that negedge.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, busy, done, ack_ok, tx_ready} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got clk/data/busy/done/ack/ready=%b exp 000000",
               {ps2_clk_drive_low, ps2_data_drive_low, busy, done, ack_ok, tx_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b exp 1", tx_ready);
    end
  endtask

  task automatic test_send_ed();
    bit ok, seen;
    logic [10:0] frame;
    int bad_k;
    logic [2:0] bad_val;
    accept_byte(8'hED, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ed_accept: got no tx_ready exp ready within bound");
    end
    bad_k   = 0;
    bad_val = 3'b000;
    for (int k = 1; k <= int'(INHIBIT) + 1; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== {1'b1, (k == int'(INHIBIT) + 1), 1'b1}
          && bad_k == 0) begin
        bad_k   = k;
        bad_val = {ps2_clk_drive_low, ps2_data_drive_low, busy};
      end
    end
    vectors++;
    if (bad_k != 0) begin
      miscompares++;
      $display("FAIL inhibit_window: cycle %0d got clk/data/busy=%b exp 1%b1",
               bad_k, bad_val, (bad_k == int'(INHIBIT) + 1));
    end
    @(negedge clk);
    vectors++;
    if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b01) begin
      miscompares++;
      $display("FAIL clock_release: got clk/data=%b exp 01", {ps2_clk_drive_low, ps2_data_drive_low});
    end
    bfm_xfer(1'b1, 11, frame, ok);
    vectors++;
    if (!ok || frame !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
      miscompares++;
      $display("FAIL ed_frame: got %b (req %b) exp %b", frame, ok, {1'b1, 1'b1, 8'hED, 1'b0});
    end
    wait_done(seen);
    vectors++;
    if (!seen || {ack_ok, busy, ps2_clk_drive_low, ps2_data_drive_low} !== 4'b1000) begin
      miscompares++;
      $display("FAIL ed_done: got seen=%b ack/busy/clk/data=%b exp 1 1000",
               seen, {ack_ok, busy, ps2_clk_drive_low, ps2_data_drive_low});
    end
    @(negedge clk);
    vectors++;
    if ({done, tx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL ed_after_done: got done/ready=%b exp 01", {done, tx_ready});
    end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    logic [10:0] frame;
    accept_byte(8'h00, ok);
    @(negedge clk);
    tx_data = 8'h01;
    vectors++;
    if (!ok || {busy, tx_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_first_accept: got ok=%b busy/ready=%b exp 1 10", ok, {busy, tx_ready});
    end
    bfm_xfer(1'b1, 11, frame, ok);
    vectors++;
    if (!ok || frame !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_frame_00: got %b exp %b", frame, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    wait_done(seen);
    vectors++;
    if (!seen || {ack_ok, tx_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_done_00: got seen=%b ack/ready=%b exp 1 10", seen, {ack_ok, tx_ready});
    end
    @(negedge clk);
    vectors++;
    if ({done, tx_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL b2b_gap: got done/ready/busy=%b exp 010", {done, tx_ready, busy});
    end
    @(negedge clk);
    tx_valid = 1'b0;
    vectors++;
    if ({busy, tx_ready, ps2_clk_drive_low} !== 3'b101) begin
      miscompares++;
      $display("FAIL b2b_second_accept: got busy/ready/clk=%b exp 101", {busy, tx_ready, ps2_clk_drive_low});
    end
    bfm_xfer(1'b1, 11, frame, ok);
    vectors++;
    if (!ok || frame !== {1'b1, 1'b0, 8'h01, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_frame_01: got %b exp %b", frame, {1'b1, 1'b0, 8'h01, 1'b0});
    end
    wait_done(seen);
    vectors++;
    if (!seen || ack_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done_01: got seen=%b ack=%b exp 1 1", seen, ack_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok, rel, early;
    accept_byte(8'h5A, ok);
    @(negedge clk);
    tx_valid = 1'b0;
    rel = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_drive_low === 1'b0) begin
        rel = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!ok || !rel || ps2_data_drive_low !== 1'b1) begin
      miscompares++;
      $display("FAIL to_release: got ok=%b rel=%b data=%b exp 1 1 1", ok, rel, ps2_data_drive_low);
    end
    early = 1'b0;
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      @(negedge clk);
      if (done !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL to_early_done: got done before %0d cycles exp none", TIMEOUT);
    end
    @(negedge clk);
    vectors++;
    if ({done, ack_ok, ps2_clk_drive_low, ps2_data_drive_low, busy} !== 5'b10000) begin
      miscompares++;
      $display("FAIL to_done: got done/ack/clk/data/busy=%b exp 10000",
               {done, ack_ok, ps2_clk_drive_low, ps2_data_drive_low, busy});
    end
    @(negedge clk);
    vectors++;
    if ({done, tx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL to_after_done: got done/ready=%b exp 01", {done, tx_ready});
    end
  endtask

  task automatic test_nack();
    bit ok, seen;
    logic [10:0] frame;
    accept_byte(8'hFF, ok);
    @(negedge clk);
    tx_valid = 1'b0;
    bfm_xfer(1'b0, 11, frame, ok);
    vectors++;
    if (!ok || frame !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL nack_frame: got %b exp %b", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
    end
    wait_done(seen);
    vectors++;
    if (!seen || {ack_ok, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL nack_done: got seen=%b ack/busy=%b exp 1 00", seen, {ack_ok, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, seen, done_seen;
    logic [10:0] frame;
    accept_byte(8'h00, ok);
    @(negedge clk);
    tx_valid = 1'b0;
    bfm_xfer(1'b1, 4, frame, ok);
    repeat (H) @(negedge clk);
    bfm_clk_low = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || {ps2_clk_drive_low, ps2_data_drive_low} !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_edge5: got ok=%b clk/data=%b exp 1 01", ok, {ps2_clk_drive_low, ps2_data_drive_low});
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, done, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: got clk/data/done/busy=%b exp 0000",
               {ps2_clk_drive_low, ps2_data_drive_low, done, busy});
    end
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen = 1'b1;
    end
    bfm_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (done !== 1'b0) done_seen = 1'b1;
    vectors++;
    if (tx_ready !== 1'b1 || done_seen) begin
      miscompares++;
      $display("FAIL mid_recover: got ready=%b done_seen=%b exp 1 0", tx_ready, done_seen);
    end
    accept_byte(8'hEE, ok);
    @(negedge clk);
    tx_valid = 1'b0;
    bfm_xfer(1'b1, 11, frame, ok);
    vectors++;
    if (!ok || frame !== {1'b1, 1'b1, 8'hEE, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_frame_ee: got %b exp %b", frame, {1'b1, 1'b1, 8'hEE, 1'b0});
    end
    wait_done(seen);
    vectors++;
    if (!seen || ack_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_done_ee: got seen=%b ack=%b exp 1 1", seen, ack_ok);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_timeout();
    test_nack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
